control_fsm: RTL and testbench

- Multicycle control unit for the 16-bit processor datapath; sits directly upstream of the datapath and drives every mux select and write enable.
- Registered 5-bit state machine: fetch, decode, execute, memory and writeback phases, decoded from the instruction register opcode.
- Also handles memory wait states, conditional-branch resolution (Zero flag), illegal-opcode trapping, halt, and a retired-instruction counter for bench/debug.

---
 rtl/control_fsm_if.sv | 31 +++
 rtl/control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_control_fsm.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Control/status bundle between the multicycle control unit and the 16-bit datapath.
// The master side is the controller; the slave side is the datapath.
interface control_fsm_if;
    logic [15:0] IROut;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite;
    logic [1:0]  PCSource;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;

    modport master (
        input  IROut, Zero, MemReady,
        output PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp
    );

    modport slave (
        output IROut, Zero, MemReady,
        input  PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp
    );
endinterface

// File: rtl/control_fsm.sv
// Multicycle control unit: fetch/decode/execute/memory/writeback sequencing with
// memory wait-state timeout, illegal-opcode trap, halt and a saturating retire counter.
module control_fsm #(
    parameter int RETIRE_W     = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                CLK,
    input  logic                Reset,
    control_fsm_if.master       bus,
    output logic [4:0]          current_state,
    output logic [4:0]          next_state,
    output logic [RETIRE_W-1:0] retired,
    output logic                halted,
    output logic                err
);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_R_EX     = 5'd2,
        S_R_WB     = 5'd3,
        S_ADDI_EX  = 5'd4,
        S_ADDI_WB  = 5'd5,
        S_MEM_ADDR = 5'd6,
        S_LW_MEM   = 5'd7,
        S_LW_WB    = 5'd8,
        S_SW_MEM   = 5'd9,
        S_BRANCH   = 5'd10,
        S_JUMP     = 5'd11,
        S_HALT     = 5'd12,
        S_TRAP     = 5'd13
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_cnt;
    logic        waiting;
    logic        retire_now;
    logic [3:0]  opcode;

    logic        pc_write;
    logic [1:0]  pc_source;
    logic        ior_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        reg_dst;
    logic        memto_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;

    assign opcode = bus.IROut[15:12];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= 8'd0;
            retired  <= '0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (waiting && state_d == state_q) ? wait_cnt + 8'd1 : 8'd0;
            if (retire_now && retired != '1) begin
                retired <= retired + RETIRE_W'(1);
            end
            if (state_d == S_TRAP) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        waiting    = 1'b0;
        retire_now = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'd0;
        ior_d      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        memto_reg  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (bus.MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    4'd0:        state_d = S_R_EX;
                    4'd1:        state_d = S_ADDI_EX;
                    4'd2, 4'd3:  state_d = S_MEM_ADDR;
                    4'd4, 4'd5:  state_d = S_BRANCH;
                    4'd6:        state_d = S_JUMP;
                    4'd15:       state_d = S_HALT;
                    default:     state_d = S_TRAP;
                endcase
            end
            S_R_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire_now = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                retire_now = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == 4'd2) ? S_LW_MEM : S_SW_MEM;
            end
            S_LW_MEM: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (bus.MemReady) state_d = S_LW_WB;
                else              waiting = 1'b1;
            end
            S_LW_WB: begin
                reg_write  = 1'b1;
                memto_reg  = 1'b1;
                retire_now = 1'b1;
                state_d    = S_FETCH;
            end
            S_SW_MEM: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
                if (bus.MemReady) begin
                    retire_now = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_BRANCH: begin
                // Only beq/bne reach here, so anything other than beq is bne.
                alu_src_a  = 1'b1;
                alu_op     = 2'd1;
                pc_source  = 2'd1;
                pc_write   = (opcode == 4'd4) ? bus.Zero : ~bus.Zero;
                retire_now = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                retire_now = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        if (waiting && wait_cnt == 8'(MEM_WAIT_MAX - 1)) begin
            state_d = S_TRAP;
        end

        // Reset aborts whatever instruction is in flight without any side effects.
        if (Reset) begin
            state_d    = S_FETCH;
            retire_now = 1'b0;
            pc_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
        end
    end

    assign bus.PCWrite   = pc_write;
    assign bus.PCSource  = pc_source;
    assign bus.IorD      = ior_d;
    assign bus.MemRead   = mem_read;
    assign bus.MemWrite  = mem_write;
    assign bus.IRWrite   = ir_write;
    assign bus.RegWrite  = reg_write;
    assign bus.RegDst    = reg_dst;
    assign bus.MemtoReg  = memto_reg;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;

    assign current_state = state_q;
    assign next_state    = state_d;
    assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm; a second instance with a 2-bit retire counter
// shadows the main one so counter saturation shows up after only a few instructions.
module tb_control_fsm;

    logic        clk;
    logic        reset;
    logic [4:0]  current_state;
    logic [4:0]  next_state;
    logic [15:0] retired;
    logic        halted;
    logic        err;
    logic [4:0]  small_state;
    logic [4:0]  small_next;
    logic [1:0]  small_retired;
    logic        small_halted;
    logic        small_err;
    int          vectors;
    int          miscompares;

    control_fsm_if bus ();
    control_fsm_if bus_small ();

    control_fsm #(.RETIRE_W(16), .MEM_WAIT_MAX(15)) dut (
        .CLK(clk), .Reset(reset), .bus(bus),
        .current_state(current_state), .next_state(next_state),
        .retired(retired), .halted(halted), .err(err)
    );

    control_fsm #(.RETIRE_W(2), .MEM_WAIT_MAX(15)) dut_small (
        .CLK(clk), .Reset(reset), .bus(bus_small),
        .current_state(small_state), .next_state(small_next),
        .retired(small_retired), .halted(small_halted), .err(small_err)
    );

    assign bus_small.IROut    = bus.IROut;
    assign bus_small.Zero     = bus.Zero;
    assign bus_small.MemReady = bus.MemReady;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] ir, input logic zero, input logic ready);
        bus.IROut    = ir;
        bus.Zero     = zero;
        bus.MemReady = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        applyStimulus(16'h0123, 1'b0, 1'b1);

        // Reset held three cycles; strobes must stay low even with MemReady high in FETCH.
        repeat (3) tick();
        checkOutput("rst_state", current_state, 0);
        checkOutput("rst_retired", retired, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_memread", bus.MemRead, 0);
        checkOutput("rst_irwrite", bus.IRWrite, 0);
        checkOutput("rst_pcwrite", bus.PCWrite, 0);
        checkOutput("rst_next", next_state, 0);

        // R-type 0x0123
        reset = 1'b0;
        #1;
        checkOutput("r_fetch_state", current_state, 0);
        checkOutput("r_fetch_irwrite", bus.IRWrite, 1);
        checkOutput("r_fetch_pcwrite", bus.PCWrite, 1);
        checkOutput("r_fetch_alusrcb", bus.ALUSrcB, 1);
        checkOutput("r_fetch_next", next_state, 1);
        tick();
        checkOutput("r_decode_state", current_state, 1);
        checkOutput("r_decode_alusrcb", bus.ALUSrcB, 3);
        checkOutput("r_decode_next", next_state, 2);
        tick();
        checkOutput("r_ex_state", current_state, 2);
        checkOutput("r_ex_aluop", bus.ALUOp, 2);
        checkOutput("r_ex_regwrite", bus.RegWrite, 0);
        tick();
        checkOutput("r_wb_state", current_state, 3);
        checkOutput("r_wb_regwrite", bus.RegWrite, 1);
        checkOutput("r_wb_regdst", bus.RegDst, 1);
        checkOutput("r_wb_memtoreg", bus.MemtoReg, 0);
        tick();
        checkOutput("r_done_state", current_state, 0);
        checkOutput("r_done_retired", retired, 1);

        // lw 0x2105 with two memory wait cycles
        applyStimulus(16'h2105, 1'b0, 1'b1);
        tick();
        checkOutput("lw_decode_state", current_state, 1);
        tick();
        checkOutput("lw_addr_state", current_state, 6);
        checkOutput("lw_addr_alusrcb", bus.ALUSrcB, 2);
        applyStimulus(16'h2105, 1'b0, 1'b0);
        tick();
        checkOutput("lw_mem1_state", current_state, 7);
        checkOutput("lw_mem1_memread", bus.MemRead, 1);
        checkOutput("lw_mem1_iord", bus.IorD, 1);
        checkOutput("lw_mem1_next", next_state, 7);
        tick();
        checkOutput("lw_mem2_state", current_state, 7);
        checkOutput("lw_mem2_memread", bus.MemRead, 1);
        applyStimulus(16'h2105, 1'b0, 1'b1);
        checkOutput("lw_mem3_iord", bus.IorD, 1);
        checkOutput("lw_mem3_next", next_state, 8);
        tick();
        checkOutput("lw_wb_state", current_state, 8);
        checkOutput("lw_wb_memtoreg", bus.MemtoReg, 1);
        checkOutput("lw_wb_regwrite", bus.RegWrite, 1);
        checkOutput("lw_wb_regdst", bus.RegDst, 0);
        tick();
        checkOutput("lw_done_retired", retired, 2);

        // beq taken, then bne not taken, both with Zero=1
        applyStimulus(16'h4012, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("beq_state", current_state, 10);
        checkOutput("beq_pcwrite", bus.PCWrite, 1);
        checkOutput("beq_pcsource", bus.PCSource, 1);
        checkOutput("beq_aluop", bus.ALUOp, 1);
        tick();
        checkOutput("beq_retired", retired, 3);
        applyStimulus(16'h5012, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("bne_state", current_state, 10);
        checkOutput("bne_pcwrite", bus.PCWrite, 0);
        tick();
        checkOutput("bne_retired", retired, 4);
        checkOutput("sat_small_retired", small_retired, 3);

        // sw 0x3105 with memory ready immediately, then j 0x6000
        applyStimulus(16'h3105, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("sw_state", current_state, 9);
        checkOutput("sw_memwrite", bus.MemWrite, 1);
        checkOutput("sw_next", next_state, 0);
        tick();
        checkOutput("sw_retired", retired, 5);
        applyStimulus(16'h6000, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("j_state", current_state, 11);
        checkOutput("j_pcsource", bus.PCSource, 2);
        checkOutput("j_pcwrite", bus.PCWrite, 1);
        tick();
        checkOutput("j_retired", retired, 6);
        checkOutput("sat_small_hold", small_retired, 3);

        // halt 0xF000
        applyStimulus(16'hF000, 1'b0, 1'b1);
        tick();
        checkOutput("halt_next", next_state, 12);
        tick();
        tick();
        checkOutput("halt_state", current_state, 12);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_retired", retired, 6);
        checkOutput("halt_memread", bus.MemRead, 0);

        // illegal opcode 0x9000 traps and err sticks until reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst2_halted", halted, 0);
        checkOutput("rst2_retired", retired, 0);
        applyStimulus(16'h9000, 1'b0, 1'b1);
        tick();
        checkOutput("trap_decode_next", next_state, 13);
        tick();
        tick();
        checkOutput("trap_state", current_state, 13);
        checkOutput("trap_err", err, 1);
        checkOutput("trap_pcwrite", bus.PCWrite, 0);
        checkOutput("trap_memread", bus.MemRead, 0);
        reset = 1'b1;
        tick();
        checkOutput("trap_rst_err", err, 0);
        checkOutput("trap_rst_state", current_state, 0);

        // MemReady stuck low in FETCH: fifteenth wait cycle heads to TRAP
        reset = 1'b0;
        applyStimulus(16'h0123, 1'b0, 1'b0);
        repeat (14) tick();
        checkOutput("tmo_last_state", current_state, 0);
        checkOutput("tmo_last_err", err, 0);
        checkOutput("tmo_next", next_state, 13);
        tick();
        checkOutput("tmo_state", current_state, 13);
        checkOutput("tmo_err", err, 1);

        // Reset asserted while lw waits in LW_MEM
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(16'h2105, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(16'h2105, 1'b0, 1'b0);
        tick();
        checkOutput("abort_lwmem_state", current_state, 7);
        reset = 1'b1;
        #1;
        checkOutput("abort_next", next_state, 0);
        checkOutput("abort_memread", bus.MemRead, 0);
        checkOutput("abort_regwrite", bus.RegWrite, 0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("abort_state", current_state, 0);
        checkOutput("abort_regwrite_after", bus.RegWrite, 0);
        checkOutput("abort_retired", retired, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
